// File: rtl/mem_port_sched_pkg.sv
// Shared definitions for the byte-port scheduler: widths, FSM encoding, grant and length codes.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mmu_pkg;

  localparam int C_DATA_L       = 32;
  localparam int M_DATA_L       = 8;
  localparam int MADDR_L        = 32;
  localparam int BYTES_PER_WORD = C_DATA_L / M_DATA_L;

  // State encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD      = 3'd1;
  localparam logic [2:0] ST_RD_TAIL = 3'd2;
  localparam logic [2:0] ST_WR      = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    RD      = ST_RD,
    RD_TAIL = ST_RD_TAIL,
    WR      = ST_WR,
    ACK     = ST_ACK
  } state_t;

  // Grant encoding; also the bit index of each requester in the arbiter req/grant vectors
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Byte count minus one
  localparam logic [1:0] LEN_1B = 2'd0;
  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_3B = 2'd2;
  localparam logic [1:0] LEN_4B = 2'd3;

  // Byte idx of a right-justified word (idx 0 = least significant byte)
  function automatic logic [M_DATA_L-1:0] be_byte(input logic [C_DATA_L-1:0] w,
                                                  input logic [1:0] idx);
    return w[M_DATA_L*idx +: M_DATA_L];
  endfunction

endpackage

// File: rtl/mem_port_sched_rr_arb2.sv
// Two-requester round-robin pick plus the last-grant register.
// Latency: grant is combinational from req; last-grant updates on the clock edge where update is high.
// Backpressure: none; the caller decides when a grant is taken via update.
// Ports: clk, rst (sync, active-low), req[1:0] (bit PORT_I / PORT_D), update, grant[1:0] one-hot.
module rr_arb2
  import mmu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last;  // port granted most recently

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the port that did not win last time gets the port
      2'b11:   grant = (last == PORT_I) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last <= PORT_I;
    end else if (update && (grant != 2'b00)) begin
      last <= grant[PORT_D] ? PORT_D : PORT_I;
    end
  end

endmodule

// File: rtl/mem_port_sched.sv
// Shares one byte-wide memory port between instruction fetch (I) and data access (D), 1-4 byte bursts.
// Latency: read N bytes -> ack N+2 edges after grant; write N bytes -> ack N+1 edges after grant.
// Backpressure: level req held until the one-cycle ack; a request arriving mid-transaction waits in req.
// Ports: clk, rst (sync active-low); I side i_req/i_addr/i_len -> i_rdata/i_ack;
//        D side d_req/d_we/d_addr/d_len/d_wdata -> d_rdata/d_ack; memory m_din, m_dout,
//        m_raddr/m_waddr, m_re/m_we byte strobes; busy = not IDLE. All outputs registered.
module mem_port_sched
  import mmu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [MADDR_L-1:0]  i_addr,
  input  logic [1:0]          i_len,
  output logic [C_DATA_L-1:0] i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [MADDR_L-1:0]  d_addr,
  input  logic [1:0]          d_len,
  input  logic [C_DATA_L-1:0] d_wdata,
  output logic [C_DATA_L-1:0] d_rdata,
  output logic                d_ack,
  input  logic [M_DATA_L-1:0] m_din,
  output logic [M_DATA_L-1:0] m_dout,
  output logic [MADDR_L-1:0]  m_raddr,
  output logic [MADDR_L-1:0]  m_waddr,
  output logic                m_re,
  output logic                m_we,
  output logic                busy
);

  state_t              state;
  logic                port;      // granted requester
  logic [MADDR_L-1:0]  addr_nxt;  // address of the next byte to issue
  logic [1:0]          len_l;
  logic [C_DATA_L-1:0] wdata_l;
  logic [2:0]          cnt;       // index of the next byte to issue
  logic [C_DATA_L-1:0] acc;
  logic                rd_pend;   // m_din carries data for the strobe two cycles back

  logic [1:0]          grant;
  logic                g_d;
  logic                g_we;
  logic [MADDR_L-1:0]  g_addr;
  logic [1:0]          g_len;
  logic                issue_done;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({d_req, i_req}),
    .update (state == IDLE),
    .grant  (grant)
  );

  always_comb begin
    g_d    = grant[PORT_D];
    g_we   = g_d & d_we;
    g_addr = g_d ? d_addr : i_addr;
    g_len  = g_d ? d_len  : i_len;
  end

  assign issue_done = (cnt > {1'b0, len_l});

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      port     <= PORT_I;
      addr_nxt <= '0;
      len_l    <= LEN_1B;
      wdata_l  <= '0;
      cnt      <= '0;
      acc      <= '0;
      rd_pend  <= 1'b0;
      i_rdata  <= '0;
      i_ack    <= 1'b0;
      d_rdata  <= '0;
      d_ack    <= 1'b0;
      m_dout   <= '0;
      m_raddr  <= '0;
      m_waddr  <= '0;
      m_re     <= 1'b0;
      m_we     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      m_re    <= 1'b0;
      m_we    <= 1'b0;
      rd_pend <= m_re;
      // MSB-first accumulation: the first byte returned ends up most significant
      if (rd_pend) acc <= {acc[C_DATA_L-M_DATA_L-1:0], m_din};

      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            port     <= g_d;
            len_l    <= g_len;
            wdata_l  <= d_wdata;
            addr_nxt <= g_addr + 1'b1;
            cnt      <= 3'd1;
            acc      <= '0;
            busy     <= 1'b1;
            // Byte 0 is strobed straight out of IDLE so no cycle is lost
            if (g_we) begin
              m_we    <= 1'b1;
              m_waddr <= g_addr;
              m_dout  <= be_byte(d_wdata, g_len);
              state   <= WR;
            end else begin
              m_re    <= 1'b1;
              m_raddr <= g_addr;
              state   <= RD;
            end
          end
        end

        RD: begin
          if (!issue_done) begin
            m_re     <= 1'b1;
            m_raddr  <= addr_nxt;
            addr_nxt <= addr_nxt + 1'b1;
            cnt      <= cnt + 3'd1;
          end else begin
            state <= RD_TAIL;
          end
        end

        RD_TAIL: begin
          // Final byte is on m_din now; fold it in directly rather than waiting for acc
          if (port == PORT_D) begin
            d_rdata <= {acc[C_DATA_L-M_DATA_L-1:0], m_din};
            d_ack   <= 1'b1;
          end else begin
            i_rdata <= {acc[C_DATA_L-M_DATA_L-1:0], m_din};
            i_ack   <= 1'b1;
          end
          state <= ACK;
        end

        WR: begin
          if (!issue_done) begin
            m_we     <= 1'b1;
            m_waddr  <= addr_nxt;
            m_dout   <= be_byte(wdata_l, len_l - cnt[1:0]);
            addr_nxt <= addr_nxt + 1'b1;
            cnt      <= cnt + 3'd1;
          end else begin
            if (port == PORT_D) d_ack <= 1'b1;
            else                i_ack <= 1'b1;
            state <= ACK;
          end
        end

        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched with a byte memory model and expectation queues.
// Latency: checks ack latency per transaction and the one-IDLE-cycle gap under contention.
// Backpressure: requesters hold req until ack, drop it on the edge that samples ack.
module tb_mem_port_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  i_len, d_len;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ack, d_ack;
  logic [7:0]  m_din, m_dout;
  logic [31:0] m_raddr, m_waddr;
  logic        m_re, m_we, busy;

  always #5 clk = ~clk;

  mem_port_sched dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_din(m_din), .m_dout(m_dout), .m_raddr(m_raddr), .m_waddr(m_waddr),
    .m_re(m_re), .m_we(m_we), .busy(busy)
  );

  // Byte memory: sparse addresses folded into a small array (top bit + low 10 bits)
  logic [7:0] mem [0:2047];

  function automatic logic [10:0] midx(input logic [31:0] a);
    return {a[31], a[9:0]};
  endfunction

  always @(posedge clk) begin
    if (m_we) mem[midx(m_waddr)] <= m_dout;
    if (m_re) m_din <= mem[midx(m_raddr)];
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [39:0] wq[$];  // {addr, byte} expected per write strobe
  logic [31:0] rq[$];  // expected read strobe addresses
  logic [31:0] iq[$];  // expected i_rdata per i_ack
  logic [31:0] dq[$];  // expected d_rdata per d_ack
  logic [31:0] cur_i = '0;
  logic [31:0] cur_d = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [63:0] e;
    chk("strobe_excl", 64'(m_re & m_we), 64'd0);
    if (m_we) begin
      if (wq.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
      else begin e = 64'(wq.pop_front()); chk("wr_addr_byte", 64'({m_waddr, m_dout}), e); end
    end
    if (m_re) begin
      if (rq.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
      else begin e = 64'(rq.pop_front()); chk("rd_addr", 64'(m_raddr), e); end
    end
    if (i_ack) begin
      if (iq.size() == 0) chk("i_ack_unexpected", 64'd1, 64'd0);
      else begin
        e = 64'(iq.pop_front());
        chk("i_rdata", 64'(i_rdata), e);
        cur_i = e[31:0];
        chk("d_rdata_hold", 64'(d_rdata), 64'(cur_d));
      end
    end
    if (d_ack) begin
      if (dq.size() == 0) chk("d_ack_unexpected", 64'd1, 64'd0);
      else begin
        e = 64'(dq.pop_front());
        chk("d_rdata", 64'(d_rdata), e);
        cur_d = e[31:0];
        chk("i_rdata_hold", 64'(i_rdata), 64'(cur_i));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 64'({i_ack, d_ack, m_re, m_we, busy}), 64'd0);
    chk({tag, "_rdata"}, {i_rdata, d_rdata}, 64'd0);
    chk({tag, "_maddr"}, {m_raddr, m_waddr}, 64'd0);
    chk({tag, "_mdout"}, 64'(m_dout), 64'd0);
  endtask

  task automatic push_exp(input bit is_d, input logic we, input logic [31:0] addr,
                          input logic [1:0] len, input logic [31:0] wdata, input logic [31:0] exp_r);
    logic [31:0] a;
    logic [31:0] sh;
    for (int k = 0; k <= int'(len); k++) begin
      a = addr + 32'(k);
      if (we) begin
        sh = wdata >> (8 * (int'(len) - k));   // big-endian: first address gets the top byte
        wq.push_back({a, sh[7:0]});
      end else begin
        rq.push_back(a);
      end
    end
    if (is_d) dq.push_back(we ? cur_d : exp_r);
    else      iq.push_back(exp_r);
  endtask

  task automatic run_txn(input bit is_d, input logic we, input logic [31:0] addr,
                         input logic [1:0] len, input logic [31:0] wdata,
                         input logic [31:0] exp_r, input int exp_lat);
    int n;
    bit done;
    push_exp(is_d, we, addr, len, wdata, exp_r);
    if (is_d) begin
      d_we = we; d_addr = addr; d_len = len; d_wdata = wdata; d_req = 1'b1;
    end else begin
      i_addr = addr; i_len = len; i_req = 1'b1;
    end
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      tick();
      n++;
      if (n == 1) chk("busy_after_grant", 64'(busy), 64'd1);
      done = is_d ? d_ack : i_ack;
    end
    chk("ack_latency", 64'(n), 64'(exp_lat));
    d_req = 1'b0;
    i_req = 1'b0;
    tick();
    chk("idle_after_ack", 64'({busy, m_re, m_we, i_ack, d_ack}), 64'd0);
  endtask

  task automatic wait_any_ack(input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end while (!(i_ack || d_ack) && n < 20);
    chk(tag, 64'(i_ack || d_ack), 64'd1);
  endtask

  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_addr = '0; i_len = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_len = '0; d_wdata = '0;

    // Reset state
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();
    chk("idle_not_busy", 64'(busy), 64'd0);

    // D write 0xDEADBEEF, then read it back through I and partially through D
    run_txn(1'b1, 1'b1, 32'h0000_0100, 2'd3, 32'hDEAD_BEEF, 32'h0, 5);
    run_txn(1'b0, 1'b0, 32'h0000_0100, 2'd3, 32'h0, 32'hDEAD_BEEF, 6);
    run_txn(1'b1, 1'b0, 32'h0000_0102, 2'd1, 32'h0, 32'h0000_BEEF, 4);
    run_txn(1'b1, 1'b0, 32'h0000_0101, 2'd0, 32'h0, 32'h0000_00AD, 3);

    // Address wrap on both write and read
    run_txn(1'b1, 1'b1, 32'hFFFF_FFFF, 2'd1, 32'h0000_A55A, 32'h0, 3);
    run_txn(1'b0, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0, 32'h0000_A55A, 4);

    // Continuous contention straight out of reset: D, I, D, I with one IDLE cycle between
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    cur_i = '0;
    cur_d = '0;
    rq.push_back(32'h100); rq.push_back(32'h103); rq.push_back(32'h100); rq.push_back(32'h103);
    dq.push_back(32'hDE);  dq.push_back(32'hDE);
    iq.push_back(32'hEF);  iq.push_back(32'hEF);
    d_we = 1'b0; d_addr = 32'h100; d_len = 2'd0;
    i_addr = 32'h103; i_len = 2'd0;
    d_req = 1'b1; i_req = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_any_ack("contend_ack_seen");
      chk("contend_order_d", 64'(d_ack), 64'((n % 2) == 0));
      if (n == 3) begin d_req = 1'b0; i_req = 1'b0; end
      tick();
      chk("contend_idle_gap", 64'({busy, m_re, m_we}), 64'd0);
      if (n < 3) begin
        tick();
        chk("contend_next_strobe", 64'(m_re), 64'd1);
      end
    end

    // Reset during the 3rd byte of a 4-byte write
    wq.push_back({32'h200, 8'h11}); wq.push_back({32'h201, 8'h22}); wq.push_back({32'h202, 8'h33});
    d_we = 1'b1; d_addr = 32'h200; d_len = 2'd3; d_wdata = 32'h1122_3344; d_req = 1'b1;
    repeat (3) tick();
    chk("abort_third_byte_on_bus", 64'({m_we, m_waddr}), 64'({1'b1, 32'h202}));
    rst = 1'b0;
    d_req = 1'b0;
    tick();
    chk_all_zero("abort");
    cur_i = '0;
    cur_d = '0;
    rst = 1'b1;
    chk("abort_byte2_written", 64'(mem[midx(32'h202)]), 64'h33);
    chk("abort_byte3_not_written", 64'(mem[midx(32'h203)] === 8'h44), 64'd0);

    // Tie after reset goes to D first
    rq.push_back(32'h200); rq.push_back(32'h201);
    dq.push_back(32'h11);  iq.push_back(32'h22);
    d_we = 1'b0; d_addr = 32'h200; d_len = 2'd0;
    i_addr = 32'h201; i_len = 2'd0;
    d_req = 1'b1; i_req = 1'b1;
    wait_any_ack("tie_ack_seen");
    chk("tie_after_reset_d", 64'({d_ack, i_ack}), 64'b10);
    d_req = 1'b0;
    wait_any_ack("tie_second_ack_seen");
    chk("tie_second_i", 64'({d_ack, i_ack}), 64'b01);
    i_req = 1'b0;
    repeat (2) tick();

    chk("queues_drained", 64'(wq.size() + rq.size() + iq.size() + dq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
